enemy_frame_decoder: RTL

- Sits directly upstream of the score controller in MULTI mode.
- Takes raw bytes from the UART receiver, sent by the opponent board's score controller.
- Validates and stability-filters each frame, then produces enemy_input, enemy_is_scored and opponent_score for the local score controller.
- Runs a link watchdog and reports whether the opponent is alive.

---
 rtl/enemy_frame_decoder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/enemy_frame_decoder.sv
// Validates and stability-filters opponent score frames, drives enemy_input/score outputs and a link watchdog.
// Optional macro FRAME_ERR_CNT_EN adds a saturating 8-bit frame_err_cnt output.
module enemy_frame_decoder #(
  parameter int STABLE_CNT     = 2,
  parameter int TIMEOUT_CYCLES = 65_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       match_restart,
  output logic [2:0] opponent_score,
  output logic       enemy_is_scored,
  output logic       enemy_input,
  output logic       link_up,
  output logic       frame_err
`ifdef FRAME_ERR_CNT_EN
  ,
  output logic [7:0] frame_err_cnt
`endif
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      STABLE_N = 4'(STABLE_CNT);

  typedef enum logic {IDLE, LINKED} state_t;

  state_t          state_q, state_d;
  logic [7:0]      cand_q, cand_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            flag_q, flag_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [2:0]      score_q, score_d;
  logic            scored_q, scored_d;
  logic            pulse_q, pulse_d;
  logic            err_q, err_d;
  logic            frame_ok;
  logic            commit;

  assign frame_ok = rx_valid && (rx_data[2:0] == 3'b111) && (rx_data[5:3] <= 3'd5);

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    flag_d   = flag_q;
    wd_d     = wd_q;
    score_d  = score_q;
    scored_d = scored_q;
    pulse_d  = 1'b0;
    err_d    = 1'b0;
    commit   = 1'b0;

    // Watchdog only runs while linked; any valid frame reloads it, even one dropped by match_restart.
    if (state_q == LINKED) begin
      if (frame_ok) begin
        wd_d = '0;
      end else if (wd_q == WD_LAST) begin
        state_d = IDLE;
        wd_d    = '0;
        cnt_d   = '0;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end else begin
      wd_d = '0;
    end

    if (match_restart) begin
      cand_d   = '0;
      cnt_d    = '0;
      flag_d   = 1'b0;
      score_d  = '0;
      scored_d = 1'b0;
    end else if (rx_valid && !frame_ok) begin
      err_d = 1'b1;
      cnt_d = '0;
    end else if (frame_ok) begin
      if (rx_data == cand_q) begin
        if (cnt_q != STABLE_N) begin
          cnt_d  = cnt_q + 4'd1;
          commit = (cnt_q == STABLE_N - 4'd1);
        end
      end else begin
        cand_d = rx_data;
        cnt_d  = 4'd1;
        commit = (STABLE_N == 4'd1);
      end
    end

    if (commit) begin
      score_d  = rx_data[5:3];
      scored_d = rx_data[6];
      pulse_d  = rx_data[7] && !flag_q;
      flag_d   = rx_data[7];
      state_d  = LINKED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cand_q   <= '0;
      cnt_q    <= '0;
      flag_q   <= 1'b0;
      wd_q     <= '0;
      score_q  <= '0;
      scored_q <= 1'b0;
      pulse_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      flag_q   <= flag_d;
      wd_q     <= wd_d;
      score_q  <= score_d;
      scored_q <= scored_d;
      pulse_q  <= pulse_d;
      err_q    <= err_d;
    end
  end

`ifdef FRAME_ERR_CNT_EN
  logic [7:0] errcnt_q, errcnt_d;

  always_comb begin
    errcnt_d = errcnt_q;
    if (err_d && (errcnt_q != 8'hFF)) errcnt_d = errcnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) errcnt_q <= '0;
    else     errcnt_q <= errcnt_d;
  end

  assign frame_err_cnt = errcnt_q;
`endif

  assign opponent_score  = score_q;
  assign enemy_is_scored = scored_q;
  assign enemy_input     = pulse_q;
  assign link_up         = (state_q == LINKED);
  assign frame_err       = err_q;

endmodule
